// File: rtl/fpr_cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpr_cdb_arbiter_if
// Bundle between the FP execution units and the FPR common-data-bus arbiter.
//
// Request side (one lane per FP unit, index 0 = fmov):
//   req_valid[N_REQ]            unit has a result to broadcast
//   req_ready[N_REQ]            one-hot grant back to the unit
//   req_tag[N_REQ][ROB_WIDTH]   ROB tag, valid in the request cycle
//   req_data[N_REQ][32]         unit's registered result, valid the cycle
//                               after the grant
// Broadcast side (seen by reservation stations, register file, ROB):
//   fpr_cdb_valid, fpr_cdb_tag, fpr_cdb_data, grant_idx (debug/perf)
//
// Modports: slave = the arbiter, master = the units/consumers around it.
// ---------------------------------------------------------------------------
interface fpr_cdb_arbiter_if #(
    parameter int N_REQ     = 6,
    parameter int ROB_WIDTH = 4
);
    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
    logic [N_REQ-1:0][31:0]          req_data;

    logic                            fpr_cdb_valid;
    logic [ROB_WIDTH-1:0]            fpr_cdb_tag;
    logic [31:0]                     fpr_cdb_data;
    logic [2:0]                      grant_idx;

    modport slave (
        input  req_valid,
        input  req_tag,
        input  req_data,
        output req_ready,
        output fpr_cdb_valid,
        output fpr_cdb_tag,
        output fpr_cdb_data,
        output grant_idx
    );

    modport master (
        output req_valid,
        output req_tag,
        output req_data,
        input  req_ready,
        input  fpr_cdb_valid,
        input  fpr_cdb_tag,
        input  fpr_cdb_data,
        input  grant_idx
    );
endinterface

// File: rtl/fpr_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// fpr_cdb_arbiter
// Round-robin arbiter for the FPR common data bus. Each cycle at most one
// requesting FP unit is granted (search starts at the round-robin pointer and
// wraps modulo N_REQ). The granted tag is registered and broadcast on the
// next cycle together with the granted unit's registered result, which the
// unit captures on the grant edge -- hence the data mux is driven by the
// registered grant index, not by the live grant.
//
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset; also blocks grants and masks the
//           broadcast in the cycle it is asserted
//   cdb_if  slave side of fpr_cdb_arbiter_if (requests in, grants and CDB out)
// ---------------------------------------------------------------------------
module fpr_cdb_arbiter #(
    parameter int N_REQ     = 6,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fpr_cdb_arbiter_if.slave     cdb_if
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     gnt_q, gnt_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_WIDTH-1:0] cdb_tag_q, cdb_tag_d;

    logic                 found;
    logic [PTR_W-1:0]     g_idx;
    logic                 dispatch;
    logic                 bcast_valid;

    // Rotating priority search: offset 0 is the pointer itself.
    always_comb begin
        int idx;
        found = 1'b0;
        g_idx = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && cdb_if.req_valid[idx]) begin
                found = 1'b1;
                g_idx = PTR_W'(idx);
            end
        end
    end

    // Grant is withheld during reset so nothing dispatches in a reset cycle.
    assign dispatch = found && !reset;

    always_comb begin
        cdb_if.req_ready = '0;
        if (dispatch) begin
            cdb_if.req_ready[g_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_valid_d = 1'b0;
        if (dispatch) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = cdb_if.req_tag[g_idx];
            gnt_d       = g_idx;
            // N_REQ need not be a power of two, so wrap explicitly.
            ptr_d       = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
        end
    end

    // A grant from the cycle before reset must not reach the bus.
    assign bcast_valid          = cdb_valid_q && !reset;
    assign cdb_if.fpr_cdb_valid = bcast_valid;
    assign cdb_if.fpr_cdb_tag   = reset ? '0 : cdb_tag_q;
    assign cdb_if.fpr_cdb_data  = bcast_valid ? cdb_if.req_data[gnt_q] : 32'h0;
    assign cdb_if.grant_idx     = bcast_valid ? 3'(gnt_q) : 3'd0;

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
module tb_fpr_cdb_arbiter;
    localparam int N  = 6;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpr_cdb_arbiter_if #(.N_REQ(N), .ROB_WIDTH(RW)) bus ();

    fpr_cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(RW)) dut (
        .clk    (clk),
        .reset  (reset),
        .cdb_if (bus)
    );

    typedef struct {
        logic                 rst;
        logic [N-1:0]         valid;
        logic [N-1:0][RW-1:0] tags;
        logic [N-1:0]         ready;
        logic                 cv;
        logic [RW-1:0]        ctag;
        logic [31:0]          cdata;
        logic [2:0]           gidx;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] D0 = 32'hBF800000;

    function automatic logic [31:0] unit_data(int k);
        return (k == 0) ? D0 : 32'h40000000 + 32'(k);
    endfunction

    // Default tags are the unit index; one unit may be overridden.
    function automatic logic [N-1:0][RW-1:0] mk_tags(int u, int v);
        logic [N-1:0][RW-1:0] t;
        for (int k = 0; k < N; k++) t[k] = RW'(k);
        if (u >= 0) t[u] = RW'(v);
        return t;
    endfunction

    task automatic add(input logic r, input logic [N-1:0] v, input logic [N-1:0][RW-1:0] t,
                       input logic [N-1:0] rdy, input logic cv, input int ctag,
                       input logic [31:0] cd, input int gi);
        vec_t e;
        e.rst = r; e.valid = v; e.tags = t; e.ready = rdy; e.cv = cv;
        e.ctag = RW'(ctag); e.cdata = cd; e.gidx = 3'(gi);
        vecs.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model state (random phase)
    int m_ptr, m_idx;
    logic m_valid;
    logic [RW-1:0] m_tag;
    int waitc[N];
    int maxw;

    // Winner = requester at the smallest forward distance from the pointer.
    function automatic int pick(logic [N-1:0] v, int p);
        int best, win, d;
        best = N; win = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - p + N) % N;
                if (d < best) begin best = d; win = i; end
            end
        end
        return win;
    endfunction

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] zero;
        logic [N-1:0][RW-1:0] dt;
        ones = '1; zero = '0; dt = mk_tags(-1, 0);

        // reset then idle; reset blocks requests
        add(1, zero, dt, 6'b000000, 0, 0, 0, 0);
        add(1, zero, dt, 6'b000000, 0, 0, 0, 0);
        add(1, ones, dt, 6'b000000, 0, 0, 0, 0);
        add(0, zero, dt, 6'b000000, 0, 0, 0, 0);
        // single request, unit 0 tag 5
        add(0, 6'b000001, mk_tags(0, 5), 6'b000001, 0, 0, 0, 0);
        add(0, zero, dt, 6'b000000, 1, 5, D0, 0);
        add(0, zero, dt, 6'b000000, 0, 5, 0, 0);
        // reset back to ptr=0, then full round robin
        add(1, zero, dt, 6'b000000, 0, 0, 0, 0);
        add(0, ones, dt, 6'b000001, 0, 0, 0, 0);
        add(0, ones, dt, 6'b000010, 1, 0, D0, 0);
        add(0, ones, dt, 6'b000100, 1, 1, unit_data(1), 1);
        add(0, ones, dt, 6'b001000, 1, 2, unit_data(2), 2);
        add(0, ones, dt, 6'b010000, 1, 3, unit_data(3), 3);
        add(0, ones, dt, 6'b100000, 1, 4, unit_data(4), 4);
        add(0, ones, dt, 6'b000001, 1, 5, unit_data(5), 5);
        add(0, zero, dt, 6'b000000, 1, 0, D0, 0);
        // move ptr to 4, then wrap-and-skip with units 1 and 5
        add(0, 6'b001000, dt, 6'b001000, 0, 0, 0, 0);
        add(0, 6'b100010, dt, 6'b100000, 1, 3, unit_data(3), 3);
        add(0, 6'b000010, dt, 6'b000010, 1, 5, unit_data(5), 5);
        add(0, zero, dt, 6'b000000, 1, 1, unit_data(1), 1);
        // back-to-back same unit (2), tags 7,8,9
        add(0, 6'b000100, mk_tags(2, 7), 6'b000100, 0, 1, 0, 0);
        add(0, 6'b000100, mk_tags(2, 8), 6'b000100, 1, 7, unit_data(2), 2);
        add(0, 6'b000100, mk_tags(2, 9), 6'b000100, 1, 8, unit_data(2), 2);
        add(0, zero, dt, 6'b000000, 1, 9, unit_data(2), 2);
        // reset mid-operation: unit 3 granted with tag 4, reset next cycle
        add(0, 6'b001000, mk_tags(3, 4), 6'b001000, 0, 9, 0, 0);
        add(1, 6'b001001, mk_tags(3, 4), 6'b000000, 0, 0, 0, 0);
        add(0, 6'b001001, mk_tags(3, 4), 6'b000001, 0, 0, 0, 0);
        add(0, 6'b001000, mk_tags(3, 4), 6'b001000, 1, 0, D0, 0);
        add(0, zero, dt, 6'b000000, 1, 4, unit_data(3), 3);

        for (int k = 0; k < N; k++) bus.req_data[k] = unit_data(k);
        bus.req_valid = '0;
        bus.req_tag   = dt;
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            bus.req_valid = vecs[i].valid;
            bus.req_tag   = vecs[i].tags;
            #4;
            chk($sformatf("r%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
            chk($sformatf("r%0d_cdb_valid", i), 32'(bus.fpr_cdb_valid), 32'(vecs[i].cv));
            chk($sformatf("r%0d_cdb_tag", i), 32'(bus.fpr_cdb_tag), 32'(vecs[i].ctag));
            chk($sformatf("r%0d_cdb_data", i), bus.fpr_cdb_data, vecs[i].cdata);
            chk($sformatf("r%0d_grant_idx", i), 32'(bus.grant_idx), 32'(vecs[i].gidx));
            @(posedge clk); #1;
        end

        // Randomized phase against the reference model; starts with a reset.
        m_ptr = 0; m_idx = 0; m_valid = 1'b0; m_tag = '0; maxw = 0;
        for (int k = 0; k < N; k++) waitc[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            int win, dens;
            logic [N-1:0] expr;
            logic ev;
            reset = (c == 0) || ($urandom_range(0, 99) == 0);
            dens = (c / 500) % 3;
            for (int k = 0; k < N; k++) begin
                bus.req_valid[k] = (dens == 0) ? ($urandom_range(0, 3) == 0)
                                 : (dens == 1) ? ($urandom_range(0, 1) == 0)
                                 : ($urandom_range(0, 7) != 0);
                bus.req_tag[k]  = RW'($urandom);
                bus.req_data[k] = $urandom;
            end
            win  = reset ? -1 : pick(bus.req_valid, m_ptr);
            expr = '0;
            if (win >= 0) expr[win] = 1'b1;
            ev = m_valid && !reset;
            #4;
            chk("rnd_ready", 32'(bus.req_ready), 32'(expr));
            chk("rnd_cdb_valid", 32'(bus.fpr_cdb_valid), 32'(ev));
            chk("rnd_cdb_tag", 32'(bus.fpr_cdb_tag), reset ? 32'h0 : 32'(m_tag));
            chk("rnd_cdb_data", bus.fpr_cdb_data, ev ? bus.req_data[m_idx] : 32'h0);
            chk("rnd_grant_idx", 32'(bus.grant_idx), ev ? 32'(m_idx) : 32'h0);
            for (int k = 0; k < N; k++) begin
                if (reset || !bus.req_valid[k] || expr[k]) waitc[k] = 0;
                else waitc[k]++;
                if (waitc[k] > maxw) maxw = waitc[k];
            end
            if (reset) begin
                m_ptr = 0; m_idx = 0; m_valid = 1'b0; m_tag = '0;
            end else if (win >= 0) begin
                m_valid = 1'b1; m_tag = bus.req_tag[win]; m_idx = win;
                m_ptr = (win + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("fairness_max_wait_le_n_minus_1", (maxw <= N - 1) ? 32'h1 : 32'(maxw), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
